// File: rtl/xs3_multi_digit_ctrl.sv
// xs3_multi_digit_ctrl
//
// Converts a DIGITS-wide packed excess-3 word into one unsigned binary value.
// One external 4-bit excess-3-to-binary converter is time-shared. Each cycle
// one digit is presented to it, most significant digit first. The result is
// accumulated as acc*10 + digit.
//
// Ports:
//   clk      - single clock, rising edge
//   rst_n    - asynchronous active-low reset
//   start    - conversion request, sampled only while idle
//   xs3_in   - packed excess-3 word, digit DIGITS-1 in the MS nibble
//   conv_x   - digit driven to the shared converter (4'h3 when not converting)
//   conv_b   - converter result for conv_x, same cycle
//   busy     - high while digits are being presented
//   done     - one-cycle pulse, bin_out valid
//   bin_out  - registered binary result, held until the next conversion completes
//   err      - sticky: an invalid digit was seen in the last conversion
module xs3_multi_digit_ctrl #(
  parameter int DIGITS = 4,
  parameter int BW     = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   xs3_in,
  output logic [3:0]            conv_x,
  input  logic [3:0]            conv_b,
  output logic                  busy,
  output logic                  done,
  output logic [BW-1:0]         bin_out,
  output logic                  err
);

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [4*DIGITS-1:0]   sh_q, sh_d;
  logic [BW-1:0]         acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [BW-1:0]         bin_out_q, bin_out_d;

  logic                  digit_valid;
  logic [BW-1:0]         acc_x10;
  logic [BW-1:0]         acc_next;

  // Outside a conversion the converter sees an excess-3 zero, so its output
  // stays benign. conv_x is kept apart from the datapath because conv_b
  // comes back through the external converter in the same cycle.
  assign conv_x  = (state_q == CONV) ? sh_q[4*DIGITS-1 -: 4] : 4'h3;
  assign busy    = (state_q == CONV);
  assign done    = (state_q == DONE);
  assign bin_out = bin_out_q;
  assign err     = err_q;

  // Excess-3 codes 3..12 are the only legal digits.
  assign digit_valid = (conv_x >= 4'd3) && (conv_x <= 4'd12);

  // acc*10 as (acc<<3)+(acc<<1), wrapping modulo 2^BW.
  assign acc_x10 = (acc_q << 3) + (acc_q << 1);

  // Next-state and datapath. The result is copied into bin_out on the edge
  // that enters DONE. It therefore appears together with the done pulse.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    bin_out_d = bin_out_q;
    acc_next  = acc_x10;

    case (state_q)
      IDLE: begin
        if (start) begin
          sh_d    = xs3_in;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = CONV;
        end
      end

      CONV: begin
        if (digit_valid) begin
          acc_next = acc_x10 + BW'(conv_b);
        end else begin
          acc_next = acc_x10;
          err_d    = 1'b1;
        end
        acc_d = acc_next;
        sh_d  = sh_q << 4;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DIGITS - 1)) begin
          bin_out_d = acc_next;
          state_d   = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      bin_out_q <= '0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      bin_out_q <= bin_out_d;
    end
  end

endmodule

// File: tb/tb_xs3_multi_digit_ctrl.sv
// Testbench for xs3_multi_digit_ctrl: default instance plus two narrow
// instances that check small-word and truncating configurations.
module tb_xs3_multi_digit_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Default instance, DIGITS=4 BW=14.
  logic        start;
  logic [15:0] xs3_in;
  logic [3:0]  conv_x, conv_b;
  logic        busy, done, err;
  logic [13:0] bin_out;

  // DIGITS=2 BW=7 instance.
  logic        start_d2;
  logic [7:0]  xs3_d2;
  logic [3:0]  conv_x_d2, conv_b_d2;
  logic        busy_d2, done_d2, err_d2;
  logic [6:0]  bin_d2;

  // DIGITS=4 BW=10 instance (result wraps).
  logic        start_tr;
  logic [15:0] xs3_tr;
  logic [3:0]  conv_x_tr, conv_b_tr;
  logic        busy_tr, done_tr, err_tr;
  logic [9:0]  bin_tr;

  // Behaviour of the shared external converter: excess-3 minus three.
  assign conv_b    = conv_x - 4'd3;
  assign conv_b_d2 = conv_x_d2 - 4'd3;
  assign conv_b_tr = conv_x_tr - 4'd3;

  int n_compared   = 0;
  int n_mismatched = 0;

  xs3_multi_digit_ctrl #(.DIGITS(4), .BW(14)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .xs3_in(xs3_in),
    .conv_x(conv_x), .conv_b(conv_b), .busy(busy), .done(done),
    .bin_out(bin_out), .err(err)
  );

  xs3_multi_digit_ctrl #(.DIGITS(2), .BW(7)) dut_d2 (
    .clk(clk), .rst_n(rst_n), .start(start_d2), .xs3_in(xs3_d2),
    .conv_x(conv_x_d2), .conv_b(conv_b_d2), .busy(busy_d2), .done(done_d2),
    .bin_out(bin_d2), .err(err_d2)
  );

  xs3_multi_digit_ctrl #(.DIGITS(4), .BW(10)) dut_tr (
    .clk(clk), .rst_n(rst_n), .start(start_tr), .xs3_in(xs3_tr),
    .conv_x(conv_x_tr), .conv_b(conv_b_tr), .busy(busy_tr), .done(done_tr),
    .bin_out(bin_tr), .err(err_tr)
  );

  // Pulse start for one edge on the default instance.
  // Call at a falling edge with the design idle. Returns at the falling edge after acceptance.
  task automatic do_start(input logic [15:0] w);
    xs3_in = w;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Count falling edges until done is seen, bounded.
  task automatic wait_main_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_compared++;
    if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %0d expected 0", busy); end
    n_compared++;
    if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_done: got %0d expected 0", done); end
    n_compared++;
    if (bin_out !== 14'd0) begin n_mismatched++; $display("[TB] FAIL reset_bin_out: got %0d expected 0", bin_out); end
    n_compared++;
    if (err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_err: got %0d expected 0", err); end
    n_compared++;
    if (conv_x !== 4'h3) begin n_mismatched++; $display("[TB] FAIL reset_conv_x: got %0h expected 3", conv_x); end
    n_compared++;
    if (bin_d2 !== 7'd0 || busy_d2 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_d2: got bin %0d busy %0d expected 0 0", bin_d2, busy_d2); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [3:0] seq [4];
    seq = '{4'h4, 4'h5, 4'h6, 4'h7};
    do_start(16'h4567);
    for (int i = 0; i < 4; i++) begin
      n_compared++;
      if (conv_x !== seq[i]) begin n_mismatched++; $display("[TB] FAIL basic_conv_x[%0d]: got %0h expected %0h", i, conv_x, seq[i]); end
      n_compared++;
      if (busy !== 1'b1 || done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_busy[%0d]: got busy %0d done %0d expected 1 0", i, busy, done); end
      @(negedge clk);
    end
    n_compared++;
    if (done !== 1'b1 || busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_done: got done %0d busy %0d expected 1 0", done, busy); end
    n_compared++;
    if (bin_out !== 14'd1234) begin n_mismatched++; $display("[TB] FAIL basic_bin_out: got %0d expected 1234", bin_out); end
    n_compared++;
    if (err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_err: got %0d expected 0", err); end
    n_compared++;
    if (conv_x !== 4'h3) begin n_mismatched++; $display("[TB] FAIL basic_conv_x_done: got %0h expected 3", conv_x); end
    @(negedge clk);
    n_compared++;
    if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_done_pulse: got %0d expected 0", done); end
  endtask

  task automatic test_values;
    int cyc;
    do_start(16'h3333);
    wait_main_done(cyc);
    n_compared++;
    if (cyc !== 4 || bin_out !== 14'd0) begin n_mismatched++; $display("[TB] FAIL zeros: got bin %0d after %0d expected 0 after 4", bin_out, cyc); end
    @(negedge clk);
    do_start(16'hCCCC);
    wait_main_done(cyc);
    n_compared++;
    if (cyc !== 4 || bin_out !== 14'h270F) begin n_mismatched++; $display("[TB] FAIL nines: got bin %0d after %0d expected 9999 after 4", bin_out, cyc); end
    n_compared++;
    if (err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL nines_err: got %0d expected 0", err); end
    @(negedge clk);
  endtask

  task automatic test_invalid;
    int cyc;
    do_start(16'h4F67);
    @(negedge clk);
    n_compared++;
    if (conv_x !== 4'hF) begin n_mismatched++; $display("[TB] FAIL invalid_conv_x: got %0h expected f", conv_x); end
    @(negedge clk);
    n_compared++;
    if (err !== 1'b1 || busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL invalid_err_mid: got err %0d busy %0d expected 1 1", err, busy); end
    wait_main_done(cyc);
    n_compared++;
    if (done !== 1'b1 || bin_out !== 14'd1034) begin n_mismatched++; $display("[TB] FAIL invalid_bin_out: got %0d done %0d expected 1034 1", bin_out, done); end
    n_compared++;
    if (err !== 1'b1) begin n_mismatched++; $display("[TB] FAIL invalid_err: got %0d expected 1", err); end
    @(negedge clk);
    do_start(16'h4567);
    n_compared++;
    if (err !== 1'b0 || bin_out !== 14'd1034) begin n_mismatched++; $display("[TB] FAIL accept_clear: got err %0d bin %0d expected 0 1034", err, bin_out); end
    wait_main_done(cyc);
    n_compared++;
    if (bin_out !== 14'd1234 || err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL after_invalid: got bin %0d err %0d expected 1234 0", bin_out, err); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int last;
    int ndone;
    int cyc;
    last  = -1;
    ndone = 0;
    xs3_in = 16'h3334;
    start  = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        n_compared++;
        if (bin_out !== 14'd1 || busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL b2b_bin_out: got bin %0d busy %0d expected 1 0", bin_out, busy); end
        if (last >= 0) begin
          n_compared++;
          if (c - last !== 6) begin n_mismatched++; $display("[TB] FAIL b2b_period: got %0d expected 6", c - last); end
        end else begin
          n_compared++;
          if (c !== 5) begin n_mismatched++; $display("[TB] FAIL b2b_first: got %0d expected 5", c); end
        end
        last = c;
      end
    end
    start = 1'b0;
    n_compared++;
    if (ndone !== 3) begin n_mismatched++; $display("[TB] FAIL b2b_count: got %0d expected 3", ndone); end
    wait_main_done(cyc);
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int seen;
    int cyc;
    do_start(16'h4567);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_compared++;
    if (busy !== 1'b0 || done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_ctrl: got busy %0d done %0d expected 0 0", busy, done); end
    n_compared++;
    if (bin_out !== 14'd0 || err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_regs: got bin %0d err %0d expected 0 0", bin_out, err); end
    n_compared++;
    if (conv_x !== 4'h3) begin n_mismatched++; $display("[TB] FAIL midrst_conv_x: got %0h expected 3", conv_x); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    n_compared++;
    if (seen !== 0) begin n_mismatched++; $display("[TB] FAIL midrst_no_done: got %0d active cycles expected 0", seen); end
    do_start(16'h3C3C);
    wait_main_done(cyc);
    n_compared++;
    if (cyc !== 4 || bin_out !== 14'd909) begin n_mismatched++; $display("[TB] FAIL midrst_after: got bin %0d after %0d expected 909 after 4", bin_out, cyc); end
    @(negedge clk);
  endtask

  task automatic test_truncation;
    int cyc;
    xs3_d2   = 8'hCC;
    start_d2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_d2 = 1'b0;
    cyc = 0;
    while (done_d2 !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_compared++;
    if (cyc !== 2 || bin_d2 !== 7'd99 || err_d2 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL d2_result: got bin %0d err %0d after %0d expected 99 0 after 2", bin_d2, err_d2, cyc); end
    @(negedge clk);
    xs3_tr   = 16'hCCCC;
    start_tr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_tr = 1'b0;
    n_compared++;
    if (busy_tr !== 1'b1) begin n_mismatched++; $display("[TB] FAIL tr_busy: got %0d expected 1", busy_tr); end
    cyc = 0;
    while (done_tr !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_compared++;
    if (cyc !== 4 || bin_tr !== 10'd783 || err_tr !== 1'b0) begin n_mismatched++; $display("[TB] FAIL tr_result: got bin %0d err %0d after %0d expected 783 0 after 4", bin_tr, err_tr, cyc); end
    @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    xs3_in   = 16'h0;
    start_d2 = 1'b0;
    xs3_d2   = 8'h0;
    start_tr = 1'b0;
    xs3_tr   = 16'h0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_values;
    test_invalid;
    test_back_to_back;
    test_reset_mid;
    test_truncation;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
